// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Consumes a framed image from the UART byte stream. The frame is a 4-byte
// little-endian word count N, then N little-endian words, then one XOR
// checksum byte. Each assembled word is written into instruction memory.
// The pipeline is held in reset until the checksum has been verified.
//
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   rx_data      - received byte, qualified by the one-cycle rx_valid strobe
//   reload       - one-cycle pulse: abort and wait for a new frame
//   imem_we      - one-cycle write strobe, registered
//   imem_addr    - word-aligned byte address of the write
//   imem_wdata   - assembled little-endian instruction word
//   core_rst     - pipeline reset, high whenever not running
//   done, error  - level status: image verified / frame rejected
module imem_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {HDR, DATA, CHK, RUN, ERR} state_t;

    // Bounds check is done on the full 32-bit count, so widen by one bit.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [1:0]  hdr_cnt;
    logic [1:0]  lane;
    logic [31:0] n_cnt;
    logic [31:0] wbuf;
    logic [31:0] word_idx;
    logic [7:0]  xsum;
    logic [31:0] idle_cnt;

    logic        accept;
    logic        counting;
    logic        timeout;
    logic [31:0] n_full;

    // reload wins over a simultaneous byte, which is dropped.
    assign accept   = rx_valid && !reload &&
                      (state == HDR || state == DATA || state == CHK);
    assign counting = (state == DATA) || (state == CHK) ||
                      (state == HDR && hdr_cnt != 2'd0);
    assign timeout  = counting && !accept && (idle_cnt == IDLE_LAST);
    assign n_full   = {rx_data, n_cnt[31:8]};

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state <= HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        core_rst   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            HDR: begin
                if (accept && hdr_cnt == 2'd3) begin
                    if ({1'b0, n_full} > MAX_WORDS)
                        state_next = ERR;
                    else if (n_full == '0)
                        state_next = CHK;
                    else
                        state_next = DATA;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            DATA: begin
                if (accept && lane == 2'd3 && (word_idx + 32'd1) == n_cnt)
                    state_next = CHK;
                else if (timeout)
                    state_next = ERR;
            end
            CHK: begin
                if (accept)
                    state_next = (rx_data == xsum) ? RUN : ERR;
                else if (timeout)
                    state_next = ERR;
            end
            RUN: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: state_next = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            hdr_cnt    <= '0;
            lane       <= '0;
            n_cnt      <= '0;
            wbuf       <= '0;
            word_idx   <= '0;
            xsum       <= '0;
            idle_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;

            if (accept)
                idle_cnt <= '0;
            else if (counting)
                idle_cnt <= idle_cnt + 32'd1;

            if (accept && (state == HDR || state == DATA))
                xsum <= xsum ^ rx_data;

            // Bytes shift in from the top so the 4th byte lands in [31:24].
            if (accept && state == HDR) begin
                n_cnt   <= n_full;
                hdr_cnt <= hdr_cnt + 2'd1;
            end

            if (accept && state == DATA) begin
                wbuf <= {rx_data, wbuf[31:8]};
                lane <= lane + 2'd1;
                if (lane == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= {rx_data, wbuf[31:8]};
                    imem_addr  <= {word_idx[29:0], 2'b00};
                    word_idx   <= word_idx + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Write log, filled on the falling edge.
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int unsigned wr_total = 0;
    int unsigned base;

    logic [7:0] frame [$];

    imem_loader #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr[wr_total[5:0]] = imem_addr;
            wr_data[wr_total[5:0]] = imem_wdata;
            wr_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Streams the queued frame with rx_valid high on every cycle.
    task automatic send_frame();
        foreach (frame[i]) send(frame[i]);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; reload = 1'b0;
        cycles(2);
        chk("rst_we",       {31'd0, imem_we},  32'd0);
        chk("rst_addr",     imem_addr,         32'd0);
        chk("rst_wdata",    imem_wdata,        32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_error",    {31'd0, error},    32'd0);
        rst = 1'b0;
        cycles(1);

        // Minimal valid frame, write pulse timing checked directly.
        base = wr_total;
        frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50};
        send_frame();
        chk("min_we_early", {31'd0, imem_we}, 32'd0);
        send(8'h00);
        chk("min_we",    {31'd0, imem_we}, 32'd1);
        chk("min_addr",  imem_addr,        32'h0);
        chk("min_wdata", imem_wdata,       32'h00500093);
        send(8'hC2);
        chk("min_we_one", {31'd0, imem_we}, 32'd0);
        chk("min_done",   {31'd0, done},    32'd1);
        chk("min_crst",   {31'd0, core_rst}, 32'd0);
        // Bytes in RUN are ignored.
        frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_frame();
        cycles(1);
        chk("min_nwr",    wr_total - base,  32'd1);
        chk("run_hold",   {31'd0, done},    32'd1);

        // Bad checksum.
        pulse_reload();
        chk("rld_done",  {31'd0, done},     32'd0);
        chk("rld_crst",  {31'd0, core_rst}, 32'd1);
        base = wr_total;
        frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        send_frame();
        chk("bad_error", {31'd0, error},    32'd1);
        chk("bad_crst",  {31'd0, core_rst}, 32'd1);
        chk("bad_done",  {31'd0, done},     32'd0);
        cycles(1);
        chk("bad_nwr",   wr_total - base,   32'd1);

        // Oversize count N=1025.
        pulse_reload();
        chk("rld_error", {31'd0, error}, 32'd0);
        base = wr_total;
        frame = '{8'h01, 8'h04, 8'h00, 8'h00};
        send_frame();
        chk("big_error", {31'd0, error}, 32'd1);
        frame = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_frame();
        cycles(1);
        chk("big_nwr",   wr_total - base, 32'd0);

        // N=1024 is the largest accepted count: no error after the header.
        pulse_reload();
        frame = '{8'h00, 8'h04, 8'h00, 8'h00};
        send_frame();
        chk("max_noerr", {31'd0, error}, 32'd0);

        // Empty image.
        pulse_reload();
        base = wr_total;
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame();
        chk("empty_done", {31'd0, done}, 32'd1);
        cycles(1);
        chk("empty_nwr",  wr_total - base, 32'd0);

        // Back-to-back three words.
        pulse_reload();
        base = wr_total;
        frame = '{8'h03, 8'h00, 8'h00, 8'h00,
                  8'h44, 8'h33, 8'h22, 8'h11,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE,
                  8'h13, 8'h00, 8'h00, 8'h00,
                  8'h76};
        send_frame();
        chk("b2b_done", {31'd0, done}, 32'd1);
        cycles(1);
        chk("b2b_nwr",   wr_total - base,        32'd3);
        chk("b2b_a0",    wr_addr[base[5:0]],      32'h0);
        chk("b2b_d0",    wr_data[base[5:0]],      32'h11223344);
        chk("b2b_a1",    wr_addr[base[5:0] + 1],  32'h4);
        chk("b2b_d1",    wr_data[base[5:0] + 1],  32'hDEADBEEF);
        chk("b2b_a2",    wr_addr[base[5:0] + 2],  32'h8);
        chk("b2b_d2",    wr_data[base[5:0] + 2],  32'h00000013);

        // Idle HDR with no bytes never times out.
        pulse_reload();
        cycles(40);
        chk("hdr_idle_err", {31'd0, error}, 32'd0);

        // Timeout after two header bytes.
        frame = '{8'h05, 8'h00};
        send_frame();
        cycles(10);
        chk("to_early", {31'd0, error}, 32'd0);
        cycles(8);
        chk("to_error", {31'd0, error}, 32'd1);

        // reload with a simultaneous byte: the byte is dropped.
        rx_data = 8'h01; rx_valid = 1'b1; reload = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; reload = 1'b0;
        chk("rv_error", {31'd0, error}, 32'd0);
        frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        send_frame();
        chk("rv_done", {31'd0, done}, 32'd1);

        // Reset mid-load, with the word-1 final byte arriving alongside rst.
        pulse_reload();
        base = wr_total;
        frame = '{8'h02, 8'h00, 8'h00, 8'h00,
                  8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h50};
        send_frame();
        rx_data = 8'h00; rx_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rst = 1'b0;
        chk("mid_we",    {31'd0, imem_we},  32'd0);
        chk("mid_addr",  imem_addr,         32'd0);
        chk("mid_wdata", imem_wdata,        32'd0);
        chk("mid_crst",  {31'd0, core_rst}, 32'd1);
        chk("mid_done",  {31'd0, done},     32'd0);
        chk("mid_error", {31'd0, error},    32'd0);
        cycles(1);
        chk("mid_nwr",   wr_total - base,   32'd1);
        base = wr_total;
        frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        send_frame();
        chk("fresh_done", {31'd0, done}, 32'd1);
        cycles(1);
        chk("fresh_nwr",  wr_total - base,    32'd1);
        chk("fresh_addr", wr_addr[base[5:0]], 32'h0);
        chk("fresh_data", wr_data[base[5:0]], 32'h00500093);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory. Receives a framed program image as a byte stream from the board UART receiver, assembles little-endian 32-bit words, and writes them sequentially into the instruction memory write port. It holds the pipeline in reset while loading and releases it only after a checksum-verified image is in place. It sits between the UART receiver and the write side of `inst_mem`/`Top`.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 10: instruction memory depth is 2^ADDR_WIDTH words.
- `TIMEOUT_CYCLES`, default 5_000_000: maximum idle gap allowed between bytes inside a frame.

**Ports**
- Clocking: one clock; reset is synchronous and active-high.
- `clk` — in, 1 — system clock.
- `rst` — in, 1 — synchronous, active-high reset.
- `rx_data` — in, 8 — received byte.
- `rx_valid` — in, 1 — one-cycle strobe; `rx_data` is valid. There is no backpressure, so every strobe is consumed.
- `reload` — in, 1 — one-cycle pulse; aborts the current state and waits for a new frame.
- `imem_we` — out, 1 — instruction memory write strobe, one cycle per word.
- `imem_addr` — out, 32 — byte address of the write, always word-aligned.
- `imem_wdata` — out, 32 — assembled instruction word.
- `core_rst` — out, 1 — reset to the pipeline; high whenever not in RUN.
- `done` — out, 1 — level; image loaded and verified.
- `error` — out, 1 — level; frame rejected.

## Operation

**Frame format** (bytes in order):
- Word count N: 4 bytes, little-endian.
- Payload: N×4 bytes, each word little-endian.
- Checksum: 1 byte, the XOR of all preceding header and payload bytes.

**States**

- **HDR**
  - Collect the 4 count bytes.
  - After the 4th byte:
    - N > 2^ADDR_WIDTH → ERR.
    - N = 0 → CHK.
    - Otherwise → DATA.
- **DATA**
  - A byte-lane counter (0–3) shifts bytes into place: byte k goes to bits [8k+7:8k].
  - On the 4th byte: issue a write at `imem_addr = word_idx*4`, then increment `word_idx`.
  - After the write of word N−1 → CHK.
- **CHK**
  - Next byte equals the running XOR → RUN.
  - Otherwise → ERR.
- **RUN**
  - `done=1`, `core_rst=0`.
  - `rx_valid` is ignored.
- **ERR**
  - `error=1`, `core_rst=1`.
  - `rx_valid` is ignored.

**Running checksum**
- The running XOR, byte-lane counter, header byte counter and `word_idx` all clear on entry to HDR.
- The running XOR accumulates every byte accepted in HDR and DATA.

**`reload`**
- Valid in any state: moves to HDR, clears `done`/`error`/counters, and drives `core_rst=1`.
- `reload` and `rx_valid` in the same cycle: `reload` wins and the byte is dropped.

**Timeout**
- An idle counter clears on every accepted byte.
- It counts while in DATA, in CHK, and in HDR once at least one header byte has arrived.
- Reaching TIMEOUT_CYCLES → ERR.
- HDR with zero bytes received never times out.

**Width rule**
- N is held in 32 bits.
- The bounds check uses the full 32-bit N, with no truncation to ADDR_WIDTH.

## Timing

**Reset values**
- State HDR.
- `imem_we=0`, `imem_addr=0`, `imem_wdata=0`.
- `core_rst=1`, `done=0`, `error=0`.
- All counters 0; XOR accumulator 0.

**Latency**
- `imem_we` is registered and pulses high exactly 1 cycle.
- The pulse occurs in the cycle after the `rx_valid` carrying the word's 4th byte.
- `imem_addr` and `imem_wdata` are valid in that same cycle and hold until the next write.

**Terminal states**
- RUN: `done` rises and `core_rst` falls in the cycle after the matching checksum byte.
- ERR: `error` rises in the cycle after the offending byte, or after the timeout count expires.

**Back-to-back input**
- `rx_valid` may be asserted on consecutive cycles with no gaps.
- Every byte must still be captured, including when a write pulse occurs in the same cycle as the next byte's arrival.

**Reset mid-frame**
- `rst` has the same effect as `reload`.
- A write in flight is not completed: `imem_we` is 0 in the cycle after `rst`.

## Test plan

- **Minimal valid frame**
  - Stimulus: bytes `01 00 00 00 93 00 50 00 C2`.
  - Required: one `imem_we` pulse with addr `0x0`, data `0x00500093`; then `done=1` and `core_rst=0`.
- **Bad checksum**
  - Stimulus: the same frame with the last byte `C3`.
  - Required: one write still occurs; `error=1`, `core_rst=1`, `done=0`.
- **Oversize and empty counts** (ADDR_WIDTH=10)
  - Header `01 04 00 00` (N=1025): ERR immediately after the 4th byte, with no writes.
  - Header `00 00 00 00` followed by checksum `00`: RUN with no writes.
- **Back-to-back multi-word**
  - Stimulus: N=3 streamed with `rx_valid` high on every cycle.
  - Required: writes at addrs `0x0`, `0x4`, `0x8` with correct data, each exactly 1 cycle, then RUN.
- **Timeout and reload** (TIMEOUT_CYCLES=16)
  - Stall 16 cycles after 2 header bytes: `error=1`.
  - Pulse `reload` together with `rx_valid`: HDR with `error=0`, and that byte is dropped.
  - A following valid frame reaches RUN.
- **Reset mid-load**
  - Stimulus: assert `rst` in the cycle after the 3rd payload byte of word 1.
  - Required: no write for word 1, all outputs at reset values, and a fresh frame loads correctly.
